// File: rtl/data_sram_bridge.sv
// Bridges the CPU's single-cycle data SRAM port onto a req/addr_ok/data_ok bus,
// one access at a time, stalling IF..EX until the bus answers.
module data_sram_bridge #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic        ex_stall,
   output logic        stallreq,
   output logic        req,
   output logic        wr,
   output logic [3:0]  wstrb,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

   state_t     state, state_next;
   logic [7:0] wait_cnt;
   logic [7:0] cnt_inc;
   logic       start;
   logic       busy;
   logic       finish;

   assign start   = (state == IDLE) && data_sram_en;
   assign busy    = (state == REQ) || (state == WAIT);
   assign finish  = ((state == REQ) && addr_ok && data_ok) || ((state == WAIT) && data_ok);
   assign cnt_inc = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 8'd1;
   assign req     = (state == REQ);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      stallreq   = 1'b0;
      case (state)
         IDLE: begin
            if (data_sram_en) begin
               state_next = REQ;
               stallreq   = 1'b1;
            end
         end
         REQ: begin
            stallreq = 1'b1;
            if (addr_ok) state_next = data_ok ? DONE : WAIT;
         end
         WAIT: begin
            stallreq = 1'b1;
            if (data_ok) state_next = DONE;
         end
         DONE: begin
            // The access instruction is still in EX while ex_stall holds it.
            if (!ex_stall) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr    <= 1'b0;
         wstrb <= 4'h0;
         addr  <= 32'h0;
         wdata <= 32'h0;
      end else if (start) begin
         wr    <= |data_sram_wen;
         wstrb <= data_sram_wen;
         addr  <= data_sram_addr;
         wdata <= data_sram_wdata;
      end
   end

   // Load data is held until the next load completes so MEM sees it late.
   always_ff @(posedge clk) begin
      if (rst)                data_sram_rdata <= 32'h0;
      else if (finish && !wr) data_sram_rdata <= rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 8'h0;
         err      <= 1'b0;
      end else if (start) begin
         wait_cnt <= 8'h0;
      end else if (busy) begin
         wait_cnt <= cnt_inc;
         if (cnt_inc == MAX_CNT) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Cycle-table and scoreboard bench for data_sram_bridge, watchdog sized to 4.
module tb_data_sram_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        ex_stall;
   logic        stallreq;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;

   always #5 clk = ~clk;

   data_sram_bridge #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata), .ex_stall(ex_stall), .stallreq(stallreq),
      .req(req), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err)
   );

   typedef struct {
      logic        r;
      logic        en;
      logic [3:0]  wen;
      logic [31:0] a;
      logic [31:0] wd;
      logic        exs;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
      logic        e_stall;
      logic        e_req;
      logic        e_wr;
      logic [31:0] e_rdata;
      logic        e_err;
      logic        push;
      logic        pop;
   } vec_t;

   localparam int NVEC = 25;
   localparam logic [31:0] D0 = 32'hDEAD_BEEF;
   localparam logic [31:0] D1 = 32'hCAFE_F00D;
   localparam logic [31:0] D2 = 32'h0BAD_CAFE;
   localparam logic [31:0] D3 = 32'h5555_AAAA;

   vec_t        tbl [NVEC];
   logic [31:0] sb_q [$];
   int          n_pass  = 0;
   int          n_total = 0;

   function automatic vec_t mk(input logic r, en, input logic [3:0] wen,
                               input logic [31:0] a, wd, input logic exs, aok, dok,
                               input logic [31:0] rd, input logic e_stall, e_req, e_wr,
                               input logic [31:0] e_rdata, input logic e_err, push, pop);
      vec_t v;
      v.r = r; v.en = en; v.wen = wen; v.a = a; v.wd = wd; v.exs = exs;
      v.aok = aok; v.dok = dok; v.rd = rd; v.e_stall = e_stall; v.e_req = e_req;
      v.e_wr = e_wr; v.e_rdata = e_rdata; v.e_err = e_err; v.push = push; v.pop = pop;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic set_in(input logic r, en, input logic [3:0] wen, input logic [31:0] a, wd,
                         input logic exs, aok, dok, input logic [31:0] rd);
      rst = r; data_sram_en = en; data_sram_wen = wen; data_sram_addr = a;
      data_sram_wdata = wd; ex_stall = exs; addr_ok = aok; data_ok = dok; rdata = rd;
   endtask

   task automatic sb_pop(input string name);
      n_total++;
      if (sb_q.size() == 0) begin
         $display("FAIL %s: got empty scoreboard, expected a pending load", name);
      end else begin
         logic [31:0] e;
         e = sb_q.pop_front();
         n_total--;
         check(name, data_sram_rdata, e);
      end
   endtask

   initial begin
      // load: addr_ok T+1, data_ok T+2
      tbl[0]  = mk(0,1,4'h0,32'h10,0, 0,0,0,0,  1,0,0,0,0, 0,0);
      tbl[1]  = mk(0,1,4'h0,32'h10,0, 0,1,0,0,  1,1,0,0,0, 0,0);
      tbl[2]  = mk(0,1,4'h0,32'h10,0, 0,0,1,D0, 1,0,0,0,0, 1,0);
      tbl[3]  = mk(0,1,4'h0,32'h10,0, 0,0,0,0,  0,0,0,D0,0, 0,1);
      tbl[4]  = mk(0,0,4'h0,32'h0,0,  0,0,0,0,  0,0,0,D0,0, 0,0);
      // store: addr_ok after 3 waiting cycles, watchdog reaches 4
      tbl[5]  = mk(0,1,4'h3,32'h20,32'h1234, 0,0,0,0, 1,0,1,D0,0, 0,0);
      tbl[6]  = mk(0,1,4'h3,32'h20,32'h1234, 0,0,0,0, 1,1,1,D0,0, 0,0);
      tbl[7]  = mk(0,1,4'h3,32'h20,32'h1234, 0,0,0,0, 1,1,1,D0,0, 0,0);
      tbl[8]  = mk(0,1,4'h3,32'h20,32'h1234, 0,0,0,0, 1,1,1,D0,0, 0,0);
      tbl[9]  = mk(0,1,4'h3,32'h20,32'h1234, 0,1,0,0, 1,1,1,D0,0, 0,0);
      tbl[10] = mk(0,1,4'h3,32'h20,32'h1234, 0,0,1,32'h9999, 1,0,1,D0,1, 0,0);
      tbl[11] = mk(0,1,4'h3,32'h20,32'h1234, 0,0,0,0, 0,0,1,D0,1, 0,0);
      tbl[12] = mk(0,0,4'h0,32'h0,0,  0,0,0,0,  0,0,0,D0,1, 0,0);
      tbl[13] = mk(1,0,4'h0,32'h0,0,  0,0,0,0,  0,0,0,D0,1, 0,0);
      // combined response, two ex_stall cycles in DONE with a stray data_ok
      tbl[14] = mk(0,1,4'h0,32'h30,0, 0,0,0,0,  1,0,0,0,0, 0,0);
      tbl[15] = mk(0,1,4'h0,32'h30,0, 0,1,1,D1, 1,1,0,0,0, 1,0);
      tbl[16] = mk(0,1,4'h0,32'h30,0, 1,0,0,0,  0,0,0,D1,0, 0,1);
      tbl[17] = mk(0,1,4'h0,32'h30,0, 1,1,1,32'h1111_1111, 0,0,0,D1,0, 0,0);
      tbl[18] = mk(0,1,4'h0,32'h30,0, 0,0,0,0,  0,0,0,D1,0, 0,0);
      // back-to-back distinct load
      tbl[19] = mk(0,1,4'h0,32'h40,0, 0,0,0,0,  1,0,0,D1,0, 0,0);
      tbl[20] = mk(0,1,4'h0,32'h40,0, 0,1,0,0,  1,1,0,D1,0, 0,0);
      tbl[21] = mk(0,1,4'h0,32'h40,0, 0,0,0,0,  1,0,0,D1,0, 0,0);
      tbl[22] = mk(0,1,4'h0,32'h40,0, 0,0,1,D2, 1,0,0,D1,0, 1,0);
      tbl[23] = mk(0,1,4'h0,32'h40,0, 0,0,0,0,  0,0,0,D2,0, 0,1);
      tbl[24] = mk(0,0,4'h0,32'h0,0,  0,0,0,0,  0,0,0,D2,0, 0,0);

      set_in(1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check("reset stallreq", stallreq, 0);
      check("reset req", req, 0);
      check("reset wr", wr, 0);
      check("reset wstrb", wstrb, 0);
      check("reset addr", addr, 0);
      check("reset wdata", wdata, 0);
      check("reset rdata", data_sram_rdata, 0);
      check("reset err", err, 0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         set_in(tbl[i].r, tbl[i].en, tbl[i].wen, tbl[i].a, tbl[i].wd,
                tbl[i].exs, tbl[i].aok, tbl[i].dok, tbl[i].rd);
         if (tbl[i].push) sb_q.push_back(tbl[i].rd);
         #1;
         check($sformatf("row%0d stallreq", i), stallreq, tbl[i].e_stall);
         check($sformatf("row%0d req", i), req, tbl[i].e_req);
         check($sformatf("row%0d rdata", i), data_sram_rdata, tbl[i].e_rdata);
         check($sformatf("row%0d err", i), err, tbl[i].e_err);
         if (tbl[i].e_req) begin
            check($sformatf("row%0d wr", i), wr, tbl[i].e_wr);
            check($sformatf("row%0d wstrb", i), wstrb, tbl[i].wen);
            check($sformatf("row%0d addr", i), addr, tbl[i].a);
            check($sformatf("row%0d wdata", i), wdata, tbl[i].wd);
         end
         if (tbl[i].pop) sb_pop($sformatf("row%0d sb load", i));
      end

      // Watchdog: no addr_ok for 6 REQ cycles while EX's address wanders.
      @(negedge clk);
      set_in(1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      set_in(0, 1, 4'h0, 32'h50, 0, 0, 0, 0, 0);
      #1;
      check("wd issue stallreq", stallreq, 1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         set_in(0, 1, 4'h0, 32'h99, 0, 0, 0, 0, 0);
         #1;
         check($sformatf("wd req cyc%0d", k), req, 1);
         check($sformatf("wd addr cyc%0d", k), addr, 32'h50);
         check($sformatf("wd err cyc%0d", k), err, (k >= 5) ? 1 : 0);
      end
      @(negedge clk);
      set_in(0, 1, 4'h0, 32'h50, 0, 0, 1, 1, D3);
      sb_q.push_back(D3);
      #1;
      check("wd late req", req, 1);
      @(negedge clk);
      set_in(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      #1;
      check("wd done stallreq", stallreq, 0);
      check("wd done err", err, 1);
      sb_pop("wd sb load");
      @(negedge clk);
      #1;
      check("wd idle err", err, 1);

      // Reset while in WAIT, then a stray data_ok.
      @(negedge clk);
      set_in(0, 1, 4'h0, 32'h60, 0, 0, 0, 0, 0);
      @(negedge clk);
      set_in(0, 1, 4'h0, 32'h60, 0, 0, 1, 0, 0);
      #1;
      check("rw req", req, 1);
      @(negedge clk);
      set_in(0, 1, 4'h0, 32'h60, 0, 0, 0, 0, 0);
      #1;
      check("rw wait stallreq", stallreq, 1);
      check("rw wait req", req, 0);
      @(negedge clk);
      set_in(1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      set_in(0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h7777_7777);
      #1;
      check("rw after req", req, 0);
      check("rw after stallreq", stallreq, 0);
      check("rw after err", err, 0);
      check("rw after rdata", data_sram_rdata, 0);
      @(negedge clk);
      set_in(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rw stray rdata", data_sram_rdata, 0);
      check("rw stray req", req, 0);
      check("rw stray stallreq", stallreq, 0);
      check("sb drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
